sha256_round_engine: RTL
========================

// Module: sha256_round_engine
// PURPOSE
//  SHA-256 compression core; consumes the W_t stream from the sigma_iter message schedule.
//  Drives the schedule's ld_rgs/upd_rgs to load one 512-bit block, then runs 64 rounds on w0.
//  Holds the 256-bit chaining value H0..H7 and adds it back at the end of the block.
//  Sits between the block padder (drives blk, first, start) and the digest consumer.
// PARAMETERS
//  ROUNDS  64  rounds per block. Only 64 is SHA-256 compliant; smaller values are for sim debug.
// PORTS
//  clk      in   1    single clock, all state on rising edge
//  rst      in   1    synchronous, active-high reset
//  start    in   1    1-cycle request to compress the block on the schedule's blk input
//  first    in   1    sampled with start: 1 = chain from IV, 0 = chain from current H
//  w0       in   32   W_t from the schedule (its top register word)
//  ld_rgs   out  1    schedule mux select: 0 = load blk, 1 = shift in new W
//  upd_rgs  out  1    schedule register enable
//  busy     out  1    high while a block is in progress
//  done     out  1    1-cycle pulse; digest holds the new H
//  digest   out  256  {H0,...,H7}, H0 in [255:224]
// BEHAVIOUR
//  Reset:
//   - state IDLE, t = 0, busy = 0, done = 0.
//   - H = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
//   - While rst = 1, upd_rgs = 0 and ld_rgs = 1.
//  FSM IDLE -> ROUND -> ADD -> IDLE:
//   - IDLE, start = 0: ld_rgs = 1, upd_rgs = 0 (schedule holds).
//   - IDLE, start = 1 (same cycle, Mealy): ld_rgs = 0, upd_rgs = 1, so the schedule loads blk.
//     On that edge: a..h <= (first ? IV : H); H <= same value; t <= 0; go to ROUND.
//     blk must be valid only in this cycle.
//   - ROUND (t = 0..ROUNDS-1): w0 = W_t.
//     T1 = h + S1(e) + Ch(e,f,g) + K[t] + w0;  T2 = S0(a) + Maj(a,b,c).
//     h<=g g<=f f<=e e<=d+T1 d<=c c<=b b<=a a<=T1+T2.
//     Drive ld_rgs = 1, upd_rgs = 1 (shift) every round; t++.
//     Leave to ADD after t = ROUNDS-1.
//   - ADD: Hi <= Hi + var_i for all 8 words; upd_rgs = 0; done <= 1 on this edge; go to IDLE.
//  Arithmetic:
//   - All adds mod 2^32.
//   - S0 = ROTR2^ROTR13^ROTR22;  S1 = ROTR6^ROTR11^ROTR25.
//   - Ch = (e&f)^(~e&g);  Maj = (a&b)^(a&c)^(b&c).
//   - K[0..63] is a combinational ROM indexed by t[5:0].
//  Timing:
//   - start accepted in cycle n -> busy high n+1..n+65, done high in cycle n+66.
//   - Exactly ROUNDS+1 upd_rgs cycles per block (1 load + ROUNDS shifts).
//  Boundary conditions:
//   - start while busy: ignored, no effect on the schedule or H.
//   - start in the done cycle: accepted (state is IDLE).
//   - digest is stable between done pulses and always equals H.
//   - Reset mid-block: abort; state, H and outputs return to reset values on the next edge.
// TESTING
//  1 "abc" padded block, first=1 -> done at +66;
//    digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
//  2 empty-message block (80000000, zeros), first=1 ->
//    e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
//  3 448-bit "abcdbcdecdefdefg...nopq": block1 first=1, block2 first=0 ->
//    248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
//  4 start pulsed at round 10 and round 40 of an "abc" run -> ignored; digest equals test 1;
//    exactly 65 upd_rgs cycles.
//  5 rst at round 30 -> busy = 0, done = 0, digest = IV next cycle;
//    a following "abc" run gives the test 1 result.
//  6 back-to-back: start asserted in the done cycle -> accepted;
//    second result matches an independent run.

Source files
------------

// File: rtl/sha256_round_engine.sv
// ---------------------------------------------------------------------------
// sha256_round_engine
// SHA-256 compression core. It loads one 512-bit block into the external
// message schedule, runs ROUNDS compression rounds on the W_t words that the
// schedule presents on w0_i, and adds the working variables back into the
// chaining value H0..H7.
//
// Ports
//   clk_i      single clock, all state changes on the rising edge
//   rst_i      synchronous active-high reset
//   start_i    1-cycle request to compress the block on the schedule's input
//   first_i    sampled with start_i: 1 = chain from IV, 0 = chain from H
//   w0_i       W_t from the schedule (its top register word)
//   ld_rgs_o   schedule mux select: 0 = load block, 1 = shift in new W
//   upd_rgs_o  schedule register enable
//   busy_o     high while a block is in progress
//   done_o     1-cycle pulse; digest_o holds the new H
//   digest_o   {H0,...,H7}, H0 in [255:224]
// ---------------------------------------------------------------------------
module sha256_round_engine #(
   parameter int ROUNDS = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         first_i,
   input  logic [31:0]  w0_i,
   output logic         ld_rgs_o,
   output logic         upd_rgs_o,
   output logic         busy_o,
   output logic         done_o,
   output logic [255:0] digest_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_ADD   = 2'd2
   } state_t;

   localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Initial hash value word for index 0..7 (H0..H7).
   function automatic logic [31:0] iv_word(input logic [2:0] idx);
      logic [31:0] w;
      case (idx)
         3'd0:    w = 32'h6a09e667;
         3'd1:    w = 32'hbb67ae85;
         3'd2:    w = 32'h3c6ef372;
         3'd3:    w = 32'ha54ff53a;
         3'd4:    w = 32'h510e527f;
         3'd5:    w = 32'h9b05688c;
         3'd6:    w = 32'h1f83d9ab;
         3'd7:    w = 32'h5be0cd19;
         default: w = 32'h00000000;
      endcase
      return w;
   endfunction

   // Round constant ROM, indexed by the 6-bit round number.
   function automatic logic [31:0] k_rom(input logic [5:0] idx);
      return K_TAB[idx];
   endfunction

   // Sigma0 on a: ROTR2 ^ ROTR13 ^ ROTR22.
   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   // Sigma1 on e: ROTR6 ^ ROTR11 ^ ROTR25.
   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ch_f(input logic [31:0] e, input logic [31:0] f,
                                        input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   state_t      state_q, state_d;
   logic [5:0]  t_q, t_d;
   logic        done_q, done_d;
   logic [31:0] hv_q   [8];
   logic [31:0] hv_d   [8];
   // Working variables a..h live at index 0..7.
   logic [31:0] work_q [8];
   logic [31:0] work_d [8];
   logic [31:0] t1_s, t2_s;
   logic        ld_rgs_s, upd_rgs_s;

   // Next-state, datapath and Mealy schedule controls.
   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      done_d    = 1'b0;
      hv_d      = hv_q;
      work_d    = work_q;
      t1_s      = 32'h00000000;
      t2_s      = 32'h00000000;
      ld_rgs_s  = 1'b1;
      upd_rgs_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               // Schedule loads the block on this same edge.
               ld_rgs_s  = 1'b0;
               upd_rgs_s = 1'b1;
               for (int i = 0; i < 8; i++) begin
                  work_d[i] = first_i ? iv_word(3'(i)) : hv_q[i];
                  hv_d[i]   = work_d[i];
               end
               t_d     = 6'd0;
               state_d = ST_ROUND;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ROUND: begin
            t1_s = work_q[7] + big_s1(work_q[4]) + ch_f(work_q[4], work_q[5], work_q[6])
                   + k_rom(t_q) + w0_i;
            t2_s = big_s0(work_q[0]) + maj_f(work_q[0], work_q[1], work_q[2]);
            work_d[7] = work_q[6];
            work_d[6] = work_q[5];
            work_d[5] = work_q[4];
            work_d[4] = work_q[3] + t1_s;
            work_d[3] = work_q[2];
            work_d[2] = work_q[1];
            work_d[1] = work_q[0];
            work_d[0] = t1_s + t2_s;
            // Shift the schedule every round so w0_i tracks W_t.
            ld_rgs_s  = 1'b1;
            upd_rgs_s = 1'b1;
            t_d       = t_q + 6'd1;
            if (t_q == T_LAST) begin
               state_d = ST_ADD;
            end else begin
               state_d = ST_ROUND;
            end
         end

         ST_ADD: begin
            for (int i = 0; i < 8; i++) begin
               hv_d[i] = hv_q[i] + work_q[i];
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Reset forces the schedule to hold regardless of state or start.
      if (rst_i) begin
         ld_rgs_s  = 1'b1;
         upd_rgs_s = 1'b0;
      end else begin
         ld_rgs_s  = ld_rgs_s;
         upd_rgs_s = upd_rgs_s;
      end
   end

   // State, counter, chaining value and working variable registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         t_q     <= 6'd0;
         done_q  <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            hv_q[i]   <= iv_word(3'(i));
            work_q[i] <= 32'h00000000;
         end
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         done_q  <= done_d;
         for (int i = 0; i < 8; i++) begin
            hv_q[i]   <= hv_d[i];
            work_q[i] <= work_d[i];
         end
      end
   end

   assign ld_rgs_o  = ld_rgs_s;
   assign upd_rgs_o = upd_rgs_s;
   assign busy_o    = (state_q != ST_IDLE);
   assign done_o    = done_q;
   assign digest_o  = {hv_q[0], hv_q[1], hv_q[2], hv_q[3],
                       hv_q[4], hv_q[5], hv_q[6], hv_q[7]};

endmodule
